// File: rtl/fml_burst_reader.sv
// fml_burst_reader: streams a linear SDRAM region over FML 4x64
// into a first-word-fall-through FIFO feeding a 64-bit stream.
// Ports: sys_clk, sys_rst_n (async, active-low);
//   start/base/count command in, busy/done status out;
//   fml_adr/fml_stb/fml_we out, fml_eack/fml_di in (FML initiator);
//   out_data/out_valid out, out_ready in (valid/ready stream).
module fml_burst_reader #(
  parameter int fml_depth       = 26,
  parameter int read_latency    = 4,
  parameter int fifo_depth_log2 = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 start,
  input  logic [fml_depth-1:0] base,
  input  logic [15:0]          count,
  output logic                 busy,
  output logic                 done,
  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  input  logic                 fml_eack,
  input  logic [63:0]          fml_di,
  output logic [63:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int L     = fifo_depth_log2;
  localparam int DEPTH = 1 << L;

  localparam logic [fml_depth-1:0] BURST =
    fml_depth'(32);
  localparam logic [fml_depth-1:0] LOW_MASK =
    fml_depth'(31);
  localparam logic [L+1:0] USED_MAX =
    (L+2)'(DEPTH - 4);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [fml_depth-1:0] adr_q;
  logic [15:0]          remaining_q;
  logic [L-1:0]         inflight_q;
  logic                 stb_q;
  logic                 stb_d;
  logic                 zero_done_q;

  logic [read_latency-1:0] dly_q;
  logic                    beat_on_q;
  logic [1:0]              beat_cnt_q;

  logic [63:0]  mem [DEPTH];
  logic [L-1:0] wr_ptr_q;
  logic [L-1:0] rd_ptr_q;
  logic [L:0]   level_q;

  logic         ack;
  logic         push;
  logic         pop;
  logic         empty;
  logic         beat_last;
  logic         drain_done;
  logic [L+1:0] used;
  logic         credit_ok;

  assign ack   = stb_q & fml_eack;
  assign empty = (level_q == '0);
  assign pop   = ~empty & out_ready;

  // The delayed ack is beat 0; beat_on covers beats 1..3.
  assign push      = dly_q[read_latency-1] | beat_on_q;
  assign beat_last = beat_on_q & (beat_cnt_q == 2'd3);

  // Each outstanding burst reserves four FIFO slots, so
  // credit >= 4 is the same as used <= DEPTH - 4.
  assign used      = {1'b0, level_q} + {inflight_q, 2'b00};
  assign credit_ok = (used <= USED_MAX);

  assign drain_done = (state_q == DRAIN)
                    & (inflight_q == '0)
                    & empty;

  assign busy      = (state_q != IDLE);
  assign done      = zero_done_q | drain_done;
  assign fml_adr   = adr_q;
  assign fml_stb   = stb_q;
  assign fml_we    = 1'b0;
  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    unique case (state_q)
      IDLE: begin
        if (start && (count != '0)) begin
          state_d = REQ;
          stb_d   = credit_ok;
        end
      end
      REQ: begin
        // A raised strobe is held until acked.
        if (ack) begin
          stb_d = 1'b0;
          if (remaining_q == 16'd1) begin
            state_d = DRAIN;
          end
        end else if (!stb_q && credit_ok) begin
          stb_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      stb_q       <= 1'b0;
      zero_done_q <= 1'b0;
      adr_q       <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      zero_done_q <= (state_q == IDLE) & start
                   & (count == '0);
      if ((state_q == IDLE) && start) begin
        adr_q       <= base & ~LOW_MASK;
        remaining_q <= count;
      end else if (ack) begin
        adr_q       <= adr_q + BURST;
        remaining_q <= remaining_q - 16'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      inflight_q <= '0;
    end else begin
      unique case (1'b1)
        ack && !beat_last:
          inflight_q <= inflight_q + L'(1);
        beat_last && !ack:
          inflight_q <= inflight_q - L'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dly_q      <= '0;
      beat_on_q  <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      dly_q[0] <= ack;
      for (int i = 1; i < read_latency; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
      if (dly_q[read_latency-1]) begin
        beat_on_q  <= 1'b1;
        beat_cnt_q <= 2'd1;
      end else if (beat_on_q) begin
        beat_cnt_q <= beat_cnt_q + 2'd1;
        if (beat_cnt_q == 2'd3) begin
          beat_on_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + L'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + L'(1);
      end
      unique case (1'b1)
        push && !pop:
          level_q <= level_q + (L+1)'(1);
        pop && !push:
          level_q <= level_q - (L+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: reads are gated by level.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= fml_di;
    end
  end

endmodule

// File: tb/tb_fml_burst_reader.sv
// tb_fml_burst_reader: directed bench with an FML responder model,
// an address scoreboard and a stream-data scoreboard.
module tb_fml_burst_reader;

  localparam int AW = 26;
  localparam int RL = 4;
  localparam int FL = 4;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          start     = 1'b0;
  logic [AW-1:0] base      = '0;
  logic [15:0]   count     = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] fml_adr;
  logic          fml_stb;
  logic          fml_we;
  logic          fml_eack  = 1'b0;
  logic [63:0]   fml_di    = '0;
  logic [63:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;

  fml_burst_reader #(
    .fml_depth      (AW),
    .read_latency   (RL),
    .fifo_depth_log2(FL)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .base     (base),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .fml_adr  (fml_adr),
    .fml_stb  (fml_stb),
    .fml_we   (fml_we),
    .fml_eack (fml_eack),
    .fml_di   (fml_di),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int            s;
    logic [AW-1:0] a;
  } burst_t;

  int            checks   = 0;
  int            errors   = 0;
  int            cyc      = 0;
  int            last_ack = -100;
  int            ack_cnt  = 0;
  int            stb_cyc  = 0;
  int            words    = 0;
  int            done_cnt = 0;
  bit            tag_adr  = 1'b0;
  bit            prev_stb = 1'b0;
  bit            prev_ack = 1'b0;
  logic [AW-1:0] prev_adr = '0;
  logic [AW-1:0] ea;
  logic [63:0]   ew;
  logic [63:0]   exp_q [$];
  logic [AW-1:0] adr_q [$];
  burst_t        pend  [$];

  function automatic logic [63:0] word(
    input logic [AW-1:0] a,
    input int            i,
    input bit            t
  );
    if (t) return {30'b0, a, 8'(i)};
    return 64'hA0 + 64'(i);
  endfunction

  task automatic chk(
    input string       name,
    input logic [63:0] got,
    input logic [63:0] want
  );
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic expect_bursts(
    input logic [AW-1:0] b,
    input int            n
  );
    logic [AW-1:0] a;
    a = b;
    for (int k = 0; k < n; k++) begin
      adr_q.push_back(a);
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(word(a, i, tag_adr));
      end
      a = a + AW'(32);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic wait_acks(input int want, input int budget);
    int n;
    n = 0;
    while (ack_cnt < want && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk("ack_wait", 64'(ack_cnt), 64'(want));
  endtask

  task automatic issue(
    input logic [AW-1:0] b,
    input logic [15:0]   c
  );
    @(posedge sys_clk);
    #1;
    base  = b;
    count = c;
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
  endtask

  // FML responder: ack on the second strobe cycle, acks at
  // least 4 cycles apart, beats from ack+RL for 4 cycles.
  initial forever begin
    @(posedge sys_clk);
    #1;
    cyc++;
    fml_eack = 1'b0;
    if (!sys_rst_n) begin
      pend.delete();
      stb_cyc  = 0;
      fml_di   = '0;
      prev_stb = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (prev_stb && !prev_ack) begin
        chk("stb_hold", 64'(fml_stb), 64'd1);
        chk("adr_hold", 64'(fml_adr), 64'(prev_adr));
      end
      if (pend.size() > 0 && cyc >= pend[0].s + 4) begin
        void'(pend.pop_front());
      end
      if (pend.size() > 0 && cyc >= pend[0].s) begin
        fml_di = word(pend[0].a, cyc - pend[0].s, tag_adr);
      end
      if (fml_stb) begin
        stb_cyc++;
        if (stb_cyc >= 2 && cyc - last_ack >= 4) begin
          fml_eack = 1'b1;
          last_ack = cyc;
          ack_cnt++;
          stb_cyc  = 0;
          pend.push_back('{cyc + RL, fml_adr});
          chk("fml_we", 64'(fml_we), 64'd0);
          if (adr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fml_adr extra burst got %h",
                     fml_adr);
          end else begin
            ea = adr_q.pop_front();
            chk("fml_adr", 64'(fml_adr), 64'(ea));
          end
        end
      end
      prev_stb = fml_stb;
      prev_ack = fml_eack;
      prev_adr = fml_adr;
    end
  end

  // Stream monitor and FIFO overflow watch.
  initial forever begin
    @(negedge sys_clk);
    if (sys_rst_n) begin
      if (done) done_cnt++;
      if (dut.push) begin
        checks++;
        if (int'(dut.level_q) >= (1 << FL)) begin
          errors++;
          $display("FAIL fifo_overflow level %0d max %0d",
                   dut.level_q, (1 << FL) - 1);
        end
      end
      if (out_valid && out_ready) begin
        words++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_data extra word got %h", out_data);
        end else begin
          ew = exp_q.pop_front();
          chk("out_data", out_data, ew);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int e;

    // Reset values and quiet idle.
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_stb",   64'(fml_stb),   64'd0);
    chk("rst_adr",   64'(fml_adr),   64'd0);
    chk("rst_we",    64'(fml_we),    64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  out_data,       64'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge sys_clk);
      seen = seen | fml_stb;
    end
    chk("idle_stb", 64'(seen), 64'd0);

    // count = 0 completes without any request.
    @(posedge sys_clk);
    #1;
    base  = 26'h00000A0;
    count = 16'd0;
    start = 1'b1;
    @(negedge sys_clk);
    chk("zero_done_early", 64'(done), 64'd0);
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    @(negedge sys_clk);
    chk("zero_done", 64'(done),    64'd1);
    chk("zero_busy", 64'(busy),    64'd0);
    chk("zero_stb",  64'(fml_stb), 64'd0);
    @(negedge sys_clk);
    chk("zero_done_once", 64'(done), 64'd0);
    chk("zero_busy2", 64'(busy),     64'd0);
    chk("zero_stb2",  64'(fml_stb),  64'd0);

    // Single burst, low address bits masked.
    tag_adr   = 1'b0;
    out_ready = 1'b1;
    done_cnt  = 0;
    words     = 0;
    ack_cnt   = 0;
    expect_bursts(26'h0001220, 1);
    issue(26'h0001234, 16'd1);
    @(negedge sys_clk);
    chk("one_busy", 64'(busy),    64'd1);
    chk("one_stb",  64'(fml_stb), 64'd1);
    chk("one_adr",  64'(fml_adr), 64'h1220);
    wait_acks(1, 20);
    e = 0;
    while (!out_valid && e < 20) begin
      @(negedge sys_clk);
      e++;
    end
    chk("first_beat_lat", 64'(cyc - last_ack), 64'd5);
    wait_done(50);
    repeat (5) @(negedge sys_clk);
    chk("one_words", 64'(words),    64'd4);
    chk("one_dones", 64'(done_cnt), 64'd1);
    chk("one_busy_end", 64'(busy),  64'd0);

    // Backpressure: credit stalls after four bursts.
    tag_adr   = 1'b1;
    out_ready = 1'b0;
    done_cnt  = 0;
    words     = 0;
    ack_cnt   = 0;
    expect_bursts(26'h0000000, 8);
    issue(26'h0000000, 16'd8);
    repeat (80) @(negedge sys_clk);
    chk("bp_acks",  64'(ack_cnt),   64'd4);
    chk("bp_stb",   64'(fml_stb),   64'd0);
    chk("bp_valid", 64'(out_valid), 64'd1);
    @(posedge sys_clk);
    #1;
    out_ready = 1'b1;
    wait_done(400);
    repeat (5) @(negedge sys_clk);
    chk("bp_acks_all", 64'(ack_cnt),  64'd8);
    chk("bp_words",    64'(words),    64'd32);
    chk("bp_dones",    64'(done_cnt), 64'd1);
    chk("bp_left", 64'(exp_q.size() + adr_q.size()), 64'd0);

    // Address wrap at the top of the space.
    done_cnt = 0;
    words    = 0;
    ack_cnt  = 0;
    expect_bursts(26'h3FFFFE0, 2);
    issue(26'h3FFFFE0, 16'd2);
    wait_done(200);
    repeat (5) @(negedge sys_clk);
    chk("wrap_acks",  64'(ack_cnt), 64'd2);
    chk("wrap_words", 64'(words),   64'd8);

    // Reset between beats 1 and 2 of burst 3.
    ack_cnt = 0;
    expect_bursts(26'h0000100, 8);
    issue(26'h0000100, 16'd8);
    wait_acks(3, 200);
    e = last_ack;
    while (cyc < e + 6) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_stb",   64'(fml_stb),   64'd0);
    chk("mid_adr",   64'(fml_adr),   64'd0);
    chk("mid_busy",  64'(busy),      64'd0);
    chk("mid_done",  64'(done),      64'd0);
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_data",  out_data,       64'd0);
    exp_q.delete();
    adr_q.delete();
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (10) @(posedge sys_clk);
    done_cnt = 0;
    words    = 0;
    ack_cnt  = 0;
    expect_bursts(26'h0000400, 1);
    issue(26'h0000400, 16'd1);
    wait_done(100);
    repeat (8) @(negedge sys_clk);
    chk("post_words", 64'(words),    64'd4);
    chk("post_acks",  64'(ack_cnt),  64'd1);
    chk("post_dones", 64'(done_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fml_burst_reader.md
# fml_burst_reader

FML 4x64 initiator that streams a linear region of SDRAM into a 64-bit valid/ready output. It issues read bursts on the FML port served by the HPDMC controller and buffers the returned beats in an internal FIFO. A credit scheme guarantees the FIFO never overflows. It sits between the memory controller's FML slave port and a consumer such as a video scanout or DMA engine.

## Interface
- `fml_depth`, 26, FML byte-address width.
- `read_latency`, 4, cycles from the `fml_eack` cycle to the first read data beat; legal values ≥1.
- `fifo_depth_log2`, 4, log2 of FIFO entries; legal values ≥2 (16 entries by default).
- `sys_clk` in 1: the single clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle command pulse.
- `base` in `fml_depth`: start byte address; the low 5 bits are ignored.
- `count` in 16: number of 32-byte bursts to read.
- `busy` out 1: a transfer is in progress.
- `done` out 1: single-cycle completion pulse.
- `fml_adr` out `fml_depth`: burst address; the low 5 bits are always 0.
- `fml_stb` out 1: request strobe.
- `fml_we` out 1: constant 0.
- `fml_eack` in 1: early acknowledge from the controller.
- `fml_di` in 64: read data beats.
- `out_data` out 64: stream data.
- `out_valid` out 1: stream data valid.
- `out_ready` in 1: consumer accepts a word.

## Operation
- The FSM has three states: IDLE, REQ and DRAIN.
- **IDLE**
  - `busy`=0.
  - On `start`, latch `base & ~0x1F` into the address register and `count` into `remaining`.
  - If `count`=0, pulse `done` on the next cycle and stay in IDLE.
  - Otherwise set `busy`=1 and go to REQ.
  - `start` is ignored while `busy`=1.
- **REQ**
  - `fml_stb` may rise only when `credit` ≥ 4, where `credit` = 2^`fifo_depth_log2` − `fifo_level` − 4·`inflight`.
  - Once high, `fml_stb` and `fml_adr` stay stable until `fml_eack`, regardless of credit. A request is never withdrawn.
  - On `fml_eack`:
    - `fml_adr` += 32, wrapping modulo 2^`fml_depth`.
    - `remaining` −= 1 and `inflight` += 1.
    - `fml_stb` drops for at least one cycle.
  - When `remaining` reaches 0, go to DRAIN.
- **DRAIN**
  - Wait until `inflight`=0 and the FIFO is empty.
  - Then pulse `done` for one cycle, clear `busy` and go to IDLE.
- **Data capture**
  - `fml_eack` is delayed by `read_latency` through a shift register. The delayed pulse loads a 2-bit beat counter.
  - On each of the 4 consecutive beat cycles, `fml_di` is written into the FIFO.
  - On the 4th beat, `inflight` −= 1.
  - The controller spaces `fml_eack` pulses at least 4 cycles apart, so data phases never overlap.
- **FIFO**
  - First-word-fall-through.
  - `out_valid` = FIFO not empty.
  - A word is popped when `out_valid` and `out_ready` are both high.
  - A push and a pop in the same cycle leave `fifo_level` unchanged.
  - Overflow is impossible by the credit rule. A write while full is a design error (assertion in the bench).
- **Simultaneous events**
  - A beat-4 decrement of `inflight` and an `fml_eack` increment in the same cycle leave `inflight` unchanged.
- **Reset**
  - Any time, including mid-burst, reset asynchronously returns the block to IDLE.
  - Reset empties the FIFO, clears `inflight`, `remaining` and the delay line, and discards in-flight data.
  - After reset the bench must allow the controller's own reset before issuing `start`.

## Timing
- Reset values: `fml_stb`=0, `fml_adr`=0, `fml_we`=0, `busy`=0, `done`=0, `out_valid`=0, `out_data`=0.
- `start` is sampled at edge N; `busy` and `fml_stb` are high from N+1, given that credit holds after reset.
- With `fml_eack` in cycle E, beats are sampled in cycles E+`read_latency` through E+`read_latency`+3.
- Beat 0 appears on `out_data` with `out_valid`=1 in cycle E+`read_latency`+1.
- `done` is high in the cycle after the last pop that leaves the FIFO empty with `inflight`=0.
- Sustained throughput is 64 bits per cycle when `out_ready` is held at 1 and the controller acks every 4 cycles.

## Test plan
1. Reset: hold `sys_rst_n`=0 -> all outputs 0. Release, idle 10 cycles -> `fml_stb` stays 0.
2. `start` with `count`=0 -> `done`=1 exactly 1 cycle later, `busy` never high, `fml_stb` never high.
3. Single burst: `base`=0x0001234, `count`=1, responder returns 0xA0..0xA3 -> `fml_adr`=0x0001220 while `fml_stb`=1. `out_data` delivers A0, A1, A2, A3 in order. `done` pulses once.
4. Backpressure: `count`=8 with `out_ready`=0 -> exactly 4 bursts are acked at 0x0, 0x20, 0x40, 0x60, after which `fml_stb` stays 0. Raising `out_ready` -> the remaining 4 bursts at 0x80 to 0xE0 are issued and 32 words arrive in address order with no loss or duplication.
5. Wrap: `base`=0x3FFFFE0, `count`=2 -> `fml_adr` is 0x3FFFFE0, then 0x0000000.
6. Reset mid-operation: assert `sys_rst_n`=0 between beats 1 and 2 of burst 3 of 8 -> outputs return to reset values immediately. A fresh `start` with `count`=1 completes with exactly 4 words delivered.
